// File: rtl/eater_pkg.sv
// Shared RAM geometry and loader state encoding for the 16x8 RAM subsystem.
package eater_pkg;

  localparam int unsigned RAM_DEPTH  = 16;
  localparam int unsigned RAM_ADDR_W = 4;
  localparam int unsigned BUS_W      = 8;

  typedef enum logic [2:0] {
    LD_IDLE      = 3'd0,
    LD_WAIT_BYTE = 3'd1,
    LD_SET_ADDR  = 3'd2,
    LD_WRITE     = 3'd3,
    LD_VERIFY    = 3'd4,
    LD_DONE      = 3'd5
  } ram_loader_state_e;

endpackage

// File: rtl/ram_loader.sv
// Program loader and RAM strobe arbiter: streams 16 bytes into RAM while the CPU is halted.
// Optional read-back check after each write is enabled by defining RAM_LOADER_VERIFY_EN.
module ram_loader
  import eater_pkg::*;
(
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [BUS_W-1:0] in_data,
  output logic             in_ready,
  input  logic             cpu_load_address,
  input  logic             cpu_ram_in,
  input  logic             cpu_ram_out,
  output logic             load_address,
  output logic             ram_in,
  output logic             ram_out,
  input  logic [BUS_W-1:0] bus_in,
  output logic             bus_drive,
  output logic [BUS_W-1:0] bus_word,
  output logic             cpu_halt,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned DEPTH  = RAM_DEPTH;
  localparam int unsigned ADDR_W = RAM_ADDR_W;
  localparam int unsigned DATA_W = BUS_W;

  ram_loader_state_e   state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_c;

  assign last_c = (addr_q == ADDR_W'(DEPTH - 1));

`ifdef RAM_LOADER_VERIFY_EN
  logic error_q, error_d;
  assign error = error_q;
`else
  logic unused_bus_in;
  assign unused_bus_in = ^bus_in;
  assign error = 1'b0;
`endif

  // Next-state and strobe decode; all loader outputs come from registered state only.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
`ifdef RAM_LOADER_VERIFY_EN
    error_d      = error_q;
`endif
    load_address = 1'b0;
    ram_in       = 1'b0;
    ram_out      = 1'b0;
    bus_drive    = 1'b0;
    bus_word     = '0;
    in_ready     = 1'b0;
    cpu_halt     = 1'b1;
    busy         = 1'b1;
    done         = 1'b0;

    unique case (state_q)
      LD_IDLE: begin
        load_address = cpu_load_address;
        ram_in       = cpu_ram_in;
        ram_out      = cpu_ram_out;
        cpu_halt     = 1'b0;
        busy         = 1'b0;
        if (start) begin
          addr_d  = '0;
`ifdef RAM_LOADER_VERIFY_EN
          error_d = 1'b0;
`endif
          state_d = LD_WAIT_BYTE;
        end
      end
      LD_WAIT_BYTE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          state_d = LD_SET_ADDR;
        end
      end
      LD_SET_ADDR: begin
        bus_drive    = 1'b1;
        bus_word     = DATA_W'(addr_q);
        load_address = 1'b1;
        state_d      = LD_WRITE;
      end
      LD_WRITE: begin
        bus_drive = 1'b1;
        bus_word  = data_q;
        ram_in    = 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
        state_d   = LD_VERIFY;
`else
        if (last_c) begin
          state_d = LD_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = LD_WAIT_BYTE;
        end
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      LD_VERIFY: begin
        ram_out = 1'b1;
        if (bus_in != data_q) error_d = 1'b1;
        if (last_c) begin
          state_d = LD_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = LD_WAIT_BYTE;
        end
      end
`endif
      LD_DONE: begin
        done    = 1'b1;
        state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef RAM_LOADER_VERIFY_EN
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef RAM_LOADER_VERIFY_EN
      error_q <= error_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader with a behavioural 16x8 RAM and MAR on the shared bus.
module tb_ram_loader;
  import eater_pkg::*;

`ifdef RAM_LOADER_VERIFY_EN
  localparam int unsigned BYTE_CYC = 4;
`else
  localparam int unsigned BYTE_CYC = 3;
`endif
  localparam int unsigned LOAD_CYC = 16 * BYTE_CYC + 1;

  logic       clk = 1'b0;
  logic       clear_n, start, in_valid;
  logic [7:0] in_data;
  logic       cpu_load_address, cpu_ram_in, cpu_ram_out;
  logic       in_ready, load_address, ram_in, ram_out, bus_drive;
  logic       cpu_halt, busy, done, error;
  logic [7:0] bus_word, bus_in, bus;

  always #5 clk = ~clk;

  ram_loader dut (
    .clk(clk), .clear_n(clear_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_load_address(cpu_load_address), .cpu_ram_in(cpu_ram_in), .cpu_ram_out(cpu_ram_out),
    .load_address(load_address), .ram_in(ram_in), .ram_out(ram_out),
    .bus_in(bus_in), .bus_drive(bus_drive), .bus_word(bus_word),
    .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error)
  );

  // Behavioural RAM + MAR; the RAM drives the bus on ram_out when the loader is not driving.
  logic [7:0]  mem [16] = '{default: 8'h00};
  logic [3:0]  mar = 4'h0;
  logic        inj_en;
  int unsigned vcnt = 0;

  assign bus    = bus_drive ? bus_word : (ram_out ? mem[mar] : 8'h00);
  assign bus_in = (inj_en && cpu_halt && ram_out && vcnt == 3) ? 8'hff : bus;

  always @(posedge clk) begin
    if (load_address) mar <= bus[3:0];
    if (ram_in) mem[mar] <= bus;
  end

  always @(posedge clk) begin
    if (start && !busy) vcnt <= 0;
    else if (cpu_halt && ram_out) vcnt <= vcnt + 1;
  end

  // Cycle monitor: accumulates counts and strobe-rule violations for later comparison.
  int unsigned halt_cnt = 0, ramin_cnt = 0, done_cnt = 0, viol = 0, halt_at_done = 0;
  logic [1:0]  nstrobe;
  assign nstrobe = 2'(load_address) + 2'(ram_in) + 2'(ram_out);

  always @(negedge clk) begin
    if (cpu_halt) halt_cnt <= halt_cnt + 1;
    if (ram_in) ramin_cnt <= ramin_cnt + 1;
    if (done) begin
      done_cnt     <= done_cnt + 1;
      halt_at_done <= halt_cnt + 1;
    end
    if (!busy) begin
      if (load_address != cpu_load_address || ram_in != cpu_ram_in || ram_out != cpu_ram_out ||
          bus_drive || cpu_halt || in_ready || done) viol <= viol + 1;
    end else if (!cpu_halt || nstrobe != ((in_ready || done) ? 2'd0 : 2'd1)) begin
      viol <= viol + 1;
    end
  end

  int unsigned n_checks = 0, n_fail = 0;
  logic [11:0] sb [$];
  logic [7:0]  exp_mem [16] = '{default: 8'h00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  task automatic run_load(input logic [7:0] base, input int stall_at, input int mid_start,
                          input int abort_after, input bit mask, input bit inj, input bit exp_err);
    int unsigned h0, r0, d0, v0, exp_halt, stall_bad;
    bit          hs, found;
    int          cyc;
    logic [11:0] e;
    exp_halt = LOAD_CYC + ((stall_at >= 0) ? 7 : 0);
    @(posedge clk); #1;
    start = 1'b1; inj_en = inj;
    @(posedge clk); #1;
    start = 1'b0;
    h0 = halt_cnt; r0 = ramin_cnt; d0 = done_cnt; v0 = viol;
    if (mask) cpu_ram_in = 1'b1;
    check("entry_busy", 32'(busy), 32'd1);
    check("entry_in_ready", 32'(in_ready), 32'd1);
    check("entry_err_clear", 32'(error), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0; stall_bad = 0; cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 10) begin @(negedge clk); cyc++; end
        for (int k = 0; k < 7; k++) begin
          if (k > 0) @(negedge clk);
          if (!in_ready || nstrobe != 2'd0) stall_bad++;
        end
        @(posedge clk); #1;
        check("stall_wait", stall_bad, 32'd0);
      end
      start    = (i == mid_start);
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      sb.push_back({4'(i), in_data});
      exp_mem[i] = in_data;
      hs = 1'b0; cyc = 0;
      while (!hs && cyc < 50) begin
        @(negedge clk); hs = in_ready;
        @(posedge clk); #1; cyc++;
      end
      check($sformatf("handshake_%0d", i), 32'(hs), 32'd1);
      start = 1'b0; in_valid = 1'b0;
      found = 1'b0; cyc = 0;
      while (!found && cyc < 6) begin
        @(negedge clk);
        if (ram_in) found = 1'b1;
        else begin @(posedge clk); #1; end
        cyc++;
      end
      check($sformatf("write_seen_%0d", i), 32'(found), 32'd1);
      if (found && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("wr_addr_%0d", i), 32'(mar), 32'(e[11:8]));
        check($sformatf("wr_data_%0d", i), 32'(bus_word), 32'(e[7:0]));
      end
      @(posedge clk); #1;
      if (i == abort_after) begin
        clear_n = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halt", 32'(cpu_halt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_bus_drive", 32'(bus_drive), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear_n = 1'b1; cpu_ram_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_done", done_cnt - d0, 32'd0);
        check("abort_ram_in_cnt", ramin_cnt - r0, 32'(i + 1));
        check("abort_strobe_rules", viol - v0, 32'd0);
        return;
      end
    end
    found = 1'b0; cyc = 0;
    while (!found && cyc < 10) begin
      @(negedge clk);
      if (done) found = 1'b1;
      cyc++;
    end
    check("done_seen", 32'(found), 32'd1);
    check("err_at_done", 32'(error), 32'(exp_err));
    if (mask) cpu_ram_in = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_halt", 32'(cpu_halt), 32'd0);
    check("halt_cycles", halt_cnt - h0, exp_halt);
    check("done_position", halt_at_done - h0, exp_halt);
    check("done_count", done_cnt - d0, 32'd1);
    check("ram_in_count", ramin_cnt - r0, 32'd16);
    check("strobe_rules", viol - v0, 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cpu_load_address = 1'b0; cpu_ram_in = 1'b0; cpu_ram_out = 1'b0; inj_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_halt", 32'(cpu_halt), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_bus_drive", 32'(bus_drive), 32'd0);
    check("reset_bus_word", 32'(bus_word), 32'd0);
    clear_n = 1'b1;
    @(posedge clk); #1;

    cpu_ram_out = 1'b1; #1;
    check("pt_ram_out", 32'(ram_out), 32'd1);
    check("pt_bus_drive", 32'(bus_drive), 32'd0);
    check("pt_halt", 32'(cpu_halt), 32'd0);
    check("pt_no_load_addr", 32'(load_address), 32'd0);
    cpu_ram_out = 1'b0; cpu_load_address = 1'b1; #1;
    check("pt_load_address", 32'(load_address), 32'd1);
    check("pt_no_ram_out", 32'(ram_out), 32'd0);
    cpu_load_address = 1'b0;

    run_load(8'h10, -1, -1, -1, 1'b0, 1'b0, 1'b0);
    check("ram0_value", 32'(mem[0]), 32'h10);
    check("ram15_value", 32'(mem[15]), 32'h1f);
    check_ram("load_a");

    run_load(8'h20, 5, -1, -1, 1'b0, 1'b0, 1'b0);
    check_ram("load_stall");

    run_load(8'h30, -1, 10, -1, 1'b1, 1'b0, 1'b0);
    check_ram("load_mask");

    run_load(8'h40, -1, -1, 7, 1'b0, 1'b0, 1'b0);
    check_ram("load_abort");

`ifdef RAM_LOADER_VERIFY_EN
    run_load(8'h50, -1, -1, -1, 1'b0, 1'b1, 1'b1);
    check("err_sticky_idle", 32'(error), 32'd1);
    run_load(8'h60, -1, -1, -1, 1'b0, 1'b0, 1'b0);
    check_ram("load_verify");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Sequencer and arbiter for the 16×8 RAM and its memory address register. Out of reset, the control unit's RAM strobes pass straight through. On `start`, the block halts the CPU and takes the bus. It then writes a 16-byte program, received over a valid/ready byte stream, into addresses 0..15, and returns RAM ownership to the control unit. It sits between the control unit, the external program source and the `ram` block on the shared 8-bit bus.

## Interface
- `DEPTH`, 16, number of RAM words written per load
- `ADDR_W`, 4, address width; DEPTH == 2**ADDR_W
- `DATA_W`, 8, bus/data width

- `clk`  in  1  system clock, rising edge
- `clear_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a program load; sampled in IDLE only
- `in_valid`  in  1  stream byte valid
- `in_data`  in  DATA_W  stream byte
- `in_ready`  out  1  loader accepts byte this cycle
- `cpu_load_address`, `cpu_ram_in`, `cpu_ram_out`  in  1 each  control-unit RAM strobes
- `load_address`, `ram_in`, `ram_out`  out  1 each  strobes to `ram`
- `bus_in`  in  DATA_W  shared bus value
- `bus_drive`  out  1  loader drives the bus
- `bus_word`  out  DATA_W  value driven when `bus_drive`=1
- `cpu_halt`  out  1  freezes control unit
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at end of load
- `error`  out  1  sticky verify mismatch (see Configuration)

## Operation
- States: IDLE, WAIT_BYTE, SET_ADDR, WRITE, [VERIFY], DONE.
- IDLE behaviour:
  - `load_address`/`ram_in`/`ram_out` = `cpu_*` combinationally.
  - `bus_drive`=0, `cpu_halt`=0, `in_ready`=0.
  - `start`=1 → clear `addr` to 0, clear `error`, go to WAIT_BYTE.
- Outside IDLE:
  - `cpu_*` inputs are ignored; the loader is the sole strobe source.
  - `cpu_halt`=1, `busy`=1.
- WAIT_BYTE: `in_ready`=1. When `in_valid`&`in_ready`, capture `in_data` into `data` and go to SET_ADDR. Otherwise stay indefinitely.
- SET_ADDR: `bus_drive`=1, `bus_word`={zeros, `addr`}, `load_address`=1 → WRITE.
- WRITE: `bus_drive`=1, `bus_word`=`data`, `ram_in`=1.
  - Go to VERIFY if compiled in.
  - Otherwise: if `addr`==DEPTH-1 → DONE, else `addr`+1 → WAIT_BYTE.
- DONE: `done`=1, `cpu_halt`=1 → IDLE.
- Exactly one of `load_address`/`ram_in`/`ram_out` is high in any loader-owned cycle; none in WAIT_BYTE or DONE.
- `addr` is ADDR_W bits and never wraps; the transition to DONE occurs at DEPTH-1.
- `start` while busy: ignored. A new byte offered outside WAIT_BYTE is held by the source (`in_ready`=0).

## Timing
- Reset (`clear_n`=0, any time, including mid-load):
  - State IDLE, `addr`=0, `data`=0, `error`=0.
  - All outputs 0 except the IDLE pass-through strobes.
  - RAM keeps any partially written contents.
- `start` high at edge N → WAIT_BYTE from N+1. `cpu_halt`, `busy` and `in_ready` are registered-state decodes, valid from N+1.
- Per byte with `in_valid` held high: 3 cycles (4 with verify).
- Full load with continuous stream: 48 cycles in WAIT/SET/WRITE, plus 1 DONE cycle. `cpu_halt` is high for 49 cycles.
- The RAM samples strobes on the rising edge ending the state's cycle. Strobes are decoded from registered state only, so they are glitch-free.

## Configuration
- `RAM_LOADER_VERIFY_EN` defined:
  - VERIFY state follows WRITE: `bus_drive`=0, `ram_out`=1.
  - At the end of the cycle, `bus_in` != `data` sets `error`. It stays set until the next `start` or reset.
  - Then advances exactly as WRITE does without verify.
  - 4 cycles/byte, 65 halted cycles per load.
- Undefined: no VERIFY state, `error` tied 0, `bus_in` unused.

## Structure
- Shared package `eater_pkg`:
  - RAM geometry constants (`RAM_DEPTH`=16, `RAM_ADDR_W`=4, `BUS_W`=8).
  - `ram_loader` state enum typedef, so bench and waveforms decode names.
- No sub-module. FSM, address counter and strobe mux fit in one module; the pass-through mux stays combinational inside it.

## Test plan
- Pass-through: IDLE, `cpu_ram_out`=1 → `ram_out`=1, `bus_drive`=0, `cpu_halt`=0. `cpu_load_address`=1 → `load_address`=1.
- Full load:
  - Pulse `start`, stream bytes 8'h10+i for i=0..15 with `in_valid` held high.
  - `done` rises exactly 49 cycles after WAIT_BYTE entry (65 with verify).
  - `ram.ram[0]`=8'h10 and `ram.ram[15]`=8'h1f.
- Stalled stream: drop `in_valid` for 7 cycles before byte 5. The FSM waits in WAIT_BYTE with `in_ready`=1, no strobes. Final contents unchanged; `done` is 7 cycles later.
- Masking:
  - Assert `cpu_ram_in`=1 throughout a load → no extra writes.
  - `start` pulsed mid-load is ignored.
  - `ram_in` is high exactly 16 cycles total.
- Reset mid-load: drive `clear_n`=0 after byte 8 for 2 cycles → `busy`=0, `cpu_halt`=0, `done` never pulses. RAM[0..7] are new; RAM[8..15] are old.
- Verify (with `RAM_LOADER_VERIFY_EN`): force `bus_in` to 8'hff during byte 3's VERIFY cycle → `error`=1 through DONE. The next `start` clears it.
